// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - issue/stall/writeback sequencer for an external multiply/divide unit
//
// Detects a mul/div instruction in decode, stalls the front end while the
// multdiv unit works, and retires the result (or an exception status write
// to r30) with a one-cycle register-file write.
//
// Optional feature: define MULTDIV_TIMEOUT_EN to compile in a BUSY-cycle
// watchdog that aborts after TIMEOUT_CYCLES cycles with exc_code 6.
//
// Ports:
//   clock           in   single clock, rising-edge
//   reset           in   asynchronous, active-high
//   opcode[4:0]     in   opcode of the instruction in decode
//   alu_op[4:0]     in   ALU op field of the instruction in decode
//   rd[4:0]         in   destination register of the instruction in decode
//   data_resultRDY  in   one-cycle result-valid pulse from the multdiv unit
//   data_exception  in   multdiv exception, qualified by data_resultRDY
//   ctrl_MULT       out  one-cycle multiply start pulse
//   ctrl_DIV        out  one-cycle divide start pulse
//   stall           out  freezes PC and fetch/decode
//   wb_en           out  one-cycle register-file write enable
//   wb_rd[4:0]      out  destination register of the wb_en write
//   wb_exc          out  write {29'b0, exc_code} to r30 instead of the result
//   exc_code[2:0]   out  4 = mul overflow, 5 = div exception, 6 = timeout

module multdiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic [4:0] alu_op,
  input  logic [4:0] rd,
  input  logic       data_resultRDY,
  input  logic       data_exception,
  output logic       ctrl_MULT,
  output logic       ctrl_DIV,
  output logic       stall,
  output logic       wb_en,
  output logic [4:0] wb_rd,
  output logic       wb_exc,
  output logic [2:0] exc_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [4:0] EXC_REG  = 5'd30;

  state_t     state;
  logic [4:0] rd_lat;    // destination captured at issue
  logic       is_div;    // op type captured at issue
  logic       exc_flag;  // retire as a status write to r30
  logic       is_md;

  assign is_md = (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

`ifdef MULTDIV_TIMEOUT_EN
  // Counter holds the number of BUSY cycles already elapsed, so the limit is
  // hit on the TIMEOUT_CYCLES-th BUSY cycle when it reads TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] busy_cnt;
  logic          timeout_hit;
  assign timeout_hit = (busy_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Stall is the only output that looks at the decode inputs directly: the
  // front end must freeze in the same cycle the mul/div is first seen.
  // Gating with reset keeps it low while reset is held even with is_md=1.
  assign stall = ~reset & (((state == IDLE) & is_md) | (state == START) | (state == BUSY));

  // The remaining outputs are decoded from flops only, so they are glitch
  // free and fall to 0 as soon as the asynchronous reset forces IDLE.
  assign ctrl_MULT = (state == START) & ~is_div;
  assign ctrl_DIV  = (state == START) &  is_div;
  assign wb_en     = (state == WB) & (exc_flag | (rd_lat != 5'd0));
  assign wb_rd     = (state == WB) ? (exc_flag ? EXC_REG : rd_lat) : 5'd0;
  assign wb_exc    = (state == WB) & exc_flag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_lat   <= 5'd0;
      is_div   <= 1'b0;
      exc_flag <= 1'b0;
      exc_code <= 3'd0;
`ifdef MULTDIV_TIMEOUT_EN
      busy_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            state  <= START;
            rd_lat <= rd;
            is_div <= (alu_op == ALU_DIV);
          end
        end

        START: begin
          state <= BUSY;
`ifdef MULTDIV_TIMEOUT_EN
          busy_cnt <= '0;
`endif
        end

        BUSY: begin
          // A result arriving on the limit cycle wins over the watchdog.
          if (data_resultRDY) begin
            state    <= WB;
            exc_flag <= data_exception;
            if (data_exception) begin
              exc_code <= is_div ? 3'd5 : 3'd4;
            end
`ifdef MULTDIV_TIMEOUT_EN
          end else if (timeout_hit) begin
            state    <= WB;
            exc_flag <= 1'b1;
            exc_code <= 3'd6;
          end else begin
            busy_cnt <= busy_cnt + CW'(1);
`endif
          end
        end

        WB: begin
          // Unconditional: the retiring instruction is still in decode this
          // cycle and must not be issued a second time.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - randomized self-checking bench for multdiv_ctrl

module tb_multdiv_ctrl;

  localparam int TO = 8;
`ifdef MULTDIV_TIMEOUT_EN
  localparam int LIMIT = TO;
`else
  localparam int LIMIT = 1 << 30;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic [4:0] alu_op = 5'd0;
  logic [4:0] rd = 5'd0;
  logic       data_resultRDY = 1'b0;
  logic       data_exception = 1'b0;
  logic       ctrl_MULT, ctrl_DIV, stall, wb_en, wb_exc;
  logic [4:0] wb_rd;
  logic [2:0] exc_code;

  multdiv_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .alu_op(alu_op), .rd(rd),
    .data_resultRDY(data_resultRDY), .data_exception(data_exception),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_exc(wb_exc), .exc_code(exc_code)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // expected outputs for the current cycle
  logic       chk = 1'b0;
  string      phase = "init";
  logic       e_mul, e_div, e_stall, e_wben, e_wbexc;
  logic [4:0] e_wbrd;
  logic [2:0] m_code = 3'd0;   // last status code reported by the model

  // observation counters for the hand-computed scenario checks
  int n_stall, n_mul, n_div, n_wb;
  logic [4:0] last_wbrd;
  logic [2:0] last_code;
  logic       last_wbexc;

  always @(negedge clock) begin
    if (chk) begin
      vectors++;
      if ({ctrl_MULT, ctrl_DIV, stall, wb_en, wb_rd, wb_exc, exc_code} !==
          {e_mul, e_div, e_stall, e_wben, e_wbrd, e_wbexc, m_code}) begin
        miscompares++;
        $display("FAIL %s @%0t: got mult=%b div=%b stall=%b wb_en=%b wb_rd=%0d wb_exc=%b code=%0d, want mult=%b div=%b stall=%b wb_en=%b wb_rd=%0d wb_exc=%b code=%0d",
                 phase, $time, ctrl_MULT, ctrl_DIV, stall, wb_en, wb_rd, wb_exc, exc_code,
                 e_mul, e_div, e_stall, e_wben, e_wbrd, e_wbexc, m_code);
      end
      if (stall === 1'b1) n_stall++;
      if (ctrl_MULT === 1'b1) n_mul++;
      if (ctrl_DIV === 1'b1) n_div++;
      if (wb_en === 1'b1) begin
        n_wb++;
        last_wbrd  = wb_rd;
        last_code  = exc_code;
        last_wbexc = wb_exc;
      end
    end
  end

  task automatic clr_obs();
    n_stall = 0; n_mul = 0; n_div = 0; n_wb = 0;
    last_wbrd = 5'd0; last_code = 3'd0; last_wbexc = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Apply one cycle of inputs together with the outputs it must produce.
  task automatic step(input string nm, input logic rst,
                      input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rdv,
                      input logic rdy, input logic exv,
                      input logic xm, input logic xd, input logic xs,
                      input logic xw, input logic [4:0] xr, input logic xe);
    reset = rst; opcode = op; alu_op = alu; rd = rdv;
    data_resultRDY = rdy; data_exception = exv;
    phase = nm; e_mul = xm; e_div = xd; e_stall = xs; e_wben = xw; e_wbrd = xr; e_wbexc = xe;
    if (rst) m_code = 3'd0;
    chk = 1'b1;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] rnd5();
    return 5'($urandom_range(0, 31));
  endfunction

  // A decode slot holding anything but mul/div.
  task automatic idle_cycle();
    logic [4:0] op, alu;
    op  = ($urandom_range(0, 1) == 0) ? 5'd0 : rnd5();
    alu = rnd5();
    if (op == 5'd0 && (alu == 5'd6 || alu == 5'd7)) alu = 5'd5;
    step("idle", 1'b0, op, alu, rnd5(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         0, 0, 0, 0, 5'd0, 0);
  endtask

  // One full mul/div instruction: result (or watchdog) on BUSY cycle n.
  task automatic do_op(input bit div, input logic [4:0] rdv, input int n,
                       input bit ex, input bit stray, input bit md_in_wb);
    logic [4:0] alu;
    bit         tmo;
    int         busy;
    alu  = div ? 5'd7 : 5'd6;
    tmo  = (n > LIMIT);
    busy = tmo ? LIMIT : n;
    step("issue", 0, 5'd0, alu, rdv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         0, 0, 1, 0, 5'd0, 0);
    step("start", 0, 5'd0, alu, rnd5(), 1'(stray), 1'($urandom_range(0, 1)),
         !div, div, 1, 0, 5'd0, 0);
    for (int i = 1; i <= busy; i++) begin
      bit r;
      r = (i == n) && !tmo;
      step("busy", 0, rnd5(), rnd5(), rnd5(), 1'(r), r ? 1'(ex) : 1'($urandom_range(0, 1)),
           0, 0, 1, 0, 5'd0, 0);
    end
    if (tmo) m_code = 3'd6;
    else if (ex) m_code = div ? 3'd5 : 3'd4;
    if (tmo || ex)
      step("wb_exc", 0, md_in_wb ? 5'd0 : 5'd3, alu, rnd5(), 1'($urandom_range(0, 1)), 0,
           0, 0, 0, 1, 5'd30, 1);
    else
      step("wb", 0, md_in_wb ? 5'd0 : 5'd3, alu, rnd5(), 1'($urandom_range(0, 1)), 0,
           0, 0, 0, (rdv != 5'd0), rdv, 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    // reset holds everything low even with a mul in decode
    clr_obs();
    for (int i = 0; i < 3; i++)
      step("reset", 1, 5'd0, 5'd6, 5'd5, 1'b1, 1'b1, 0, 0, 0, 0, 5'd0, 0);
    check("reset_no_stall", n_stall, 0);

    // mul rd=5, result on BUSY cycle 10
    clr_obs();
    do_op(0, 5'd5, 10, 0, 0, 0);
    check("mul_stall_cycles", n_stall, 12);
    check("mul_pulses", n_mul, 1);
    check("mul_wb_count", n_wb, 1);
    check("mul_wb_rd", last_wbrd, 5);
    check("mul_wb_exc", last_wbexc, 0);

    // div rd=7 with exception
    idle_cycle();
    clr_obs();
    do_op(1, 5'd7, 4, 1, 0, 0);
    check("div_pulses", n_div, 1);
    check("div_exc_rd", last_wbrd, 30);
    check("div_exc_code", last_code, 5);

    // mul rd=0 retires without a write
    clr_obs();
    do_op(0, 5'd0, 1, 0, 0, 0);
    check("rd0_stall_cycles", n_stall, 3);
    check("rd0_wb_count", n_wb, 0);

    // stray RDY in START ignored, real RDY on BUSY cycle 3
    clr_obs();
    do_op(0, 5'd12, 3, 0, 1, 1);
    check("stray_stall_cycles", n_stall, 5);
    check("stray_wb_rd", last_wbrd, 12);

    // mul overflow reports code 4
    clr_obs();
    do_op(0, 5'd9, 2, 1, 0, 0);
    check("mul_exc_code", last_code, 4);

    // reset in BUSY cycle 4 drops the op; reissue after release
    clr_obs();
    step("issue", 0, 5'd0, 5'd6, 5'd9, 0, 0, 0, 0, 1, 0, 5'd0, 0);
    step("start", 0, 5'd0, 5'd6, 5'd9, 0, 0, 1, 0, 1, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++)
      step("busy", 0, 5'd0, 5'd6, 5'd9, 0, 0, 0, 0, 1, 0, 5'd0, 0);
    step("busy_reset", 1, 5'd0, 5'd6, 5'd9, 1, 0, 0, 0, 0, 0, 5'd0, 0);
    step("busy_reset", 1, 5'd0, 5'd6, 5'd9, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    check("reset_drop_wb", n_wb, 0);
    clr_obs();
    do_op(0, 5'd9, 2, 0, 0, 0);
    check("reissue_pulses", n_mul, 1);
    check("reissue_wb_rd", last_wbrd, 9);

    // long wait: watchdog abort when enabled, normal result otherwise
    clr_obs();
    do_op(1, 5'd4, 20, 0, 0, 0);
`ifdef MULTDIV_TIMEOUT_EN
    check("timeout_stall_cycles", n_stall, 2 + TO);
    check("timeout_code", last_code, 6);
    check("timeout_rd", last_wbrd, 30);
`else
    check("long_stall_cycles", n_stall, 22);
    check("long_wb_rd", last_wbrd, 4);
`endif
    // result on the limit cycle is taken normally
    clr_obs();
    do_op(0, 5'd6, TO, 0, 0, 0);
    check("limit_wb_exc", last_wbexc, 0);
    check("limit_wb_rd", last_wbrd, 6);

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      do_op(1'($urandom_range(0, 1)), rnd5(), $urandom_range(1, 12),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        step("rand_reset", 1, 5'd0, 5'd7, rnd5(), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 5'd0, 0);
      end
      for (int j = $urandom_range(0, 2); j > 0; j--) idle_cycle();
    end

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, number of BUSY cycles before a watchdog abort; used only when MULTDIV_TIMEOUT_EN is defined.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 opcode  in  5  opcode of the instruction currently in decode.
REQ-005 alu_op  in  5  ALU op field of the instruction in decode.
REQ-006 rd  in  5  destination register of the instruction in decode.
REQ-007 data_resultRDY  in  1  one-cycle pulse from the multdiv unit: result valid.
REQ-008 data_exception  in  1  multdiv exception, valid with data_resultRDY.
REQ-009 ctrl_MULT  out  1  one-cycle start pulse to the multdiv unit for multiply.
REQ-010 ctrl_DIV  out  1  one-cycle start pulse to the multdiv unit for divide.
REQ-011 stall  out  1  freezes PC and fetch/decode.
REQ-012 wb_en  out  1  one-cycle register-file write enable for the multdiv result.
REQ-013 wb_rd  out  5  destination register for the wb_en write.
REQ-014 wb_exc  out  1  with wb_en: write {29'b0, exc_code} to r30 instead of the result.
REQ-015 exc_code  out  3  status code: 4 = mul overflow, 5 = div exception, 6 = timeout.

Function
REQ-016 is_md SHALL be opcode==00000 && (alu_op==00110 (mul) || alu_op==00111 (div)).
REQ-017 The FSM SHALL have four states: IDLE, START, BUSY, WB.
REQ-018 IDLE -> START SHALL occur when is_md=1; the block SHALL latch rd and the op type (mul/div) on that edge.
REQ-019 In START, the block SHALL assert exactly one of ctrl_MULT/ctrl_DIV for that one cycle, and SHALL go to BUSY next.
REQ-020 BUSY -> WB SHALL occur on the cycle data_resultRDY=1; it SHALL latch data_exception.
REQ-021 data_resultRDY SHALL be ignored in IDLE, START and WB.
REQ-022 WB -> IDLE SHALL be unconditional; is_md SHALL be ignored in WB, so the same instruction is not reissued.
REQ-023 stall SHALL be (IDLE && is_md) || START || BUSY, and SHALL be 0 in WB so the PC advances on the retire cycle.
REQ-024 In WB without exception, wb_en SHALL be 1 if the latched rd!=0 and 0 otherwise; wb_rd SHALL be the latched rd; wb_exc SHALL be 0.
REQ-025 In WB with exception, wb_en SHALL be 1, wb_rd SHALL be 30 and wb_exc SHALL be 1; exc_code SHALL be 4 for mul and 5 for div.
REQ-026 Outside WB, wb_en, wb_exc, ctrl_MULT and ctrl_DIV SHALL be 0; exc_code SHALL hold its last value.
REQ-027 Latency SHALL be 1 cycle from the data_resultRDY edge to the WB cycle; a minimum op SHALL take 3 stall cycles plus 1 WB cycle.

Reset
REQ-028 While reset=1, the FSM SHALL be IDLE and all outputs SHALL be 0, including stall, regardless of is_md.
REQ-029 Reset mid-operation SHALL drop the pending op with no writeback; after deassertion, the block SHALL reissue if is_md=1.
REQ-030 Reset SHALL clear the latched rd, the op type, the exception flag and the timeout counter to 0.

Configuration
REQ-031 Macro MULTDIV_TIMEOUT_EN SHALL compile in a BUSY-cycle counter; it SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-032 With MULTDIV_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES with no data_resultRDY, the block SHALL go to WB with wb_rd=30, wb_exc=1 and exc_code=6.
REQ-033 With MULTDIV_TIMEOUT_EN defined, if data_resultRDY arrives on the limit cycle, the block SHALL take the normal result and SHALL NOT raise a timeout.
REQ-034 Without MULTDIV_TIMEOUT_EN, there SHALL be no counter and BUSY SHALL wait indefinitely.

Verification
REQ-035 mul, rd=5, RDY after 10 BUSY cycles: ctrl_MULT is high for 1 cycle; stall is high for 12 cycles; then wb_en=1, wb_rd=5, wb_exc=0.
REQ-036 div, rd=7, RDY with exception=1: ctrl_DIV pulses once; WB has wb_rd=30, wb_exc=1, exc_code=5.
REQ-037 mul with rd=0, no exception: the full sequence runs and wb_en=0 in WB.
REQ-038 Stray RDY in START, then RDY in BUSY cycle 3: the stray is ignored and WB follows the BUSY RDY.
REQ-039 reset asserted in BUSY cycle 4: all outputs drop to 0 immediately; no wb_en; after release with is_md=1, START recurs.
REQ-040 MULTDIV_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no RDY: WB after 8 BUSY cycles with exc_code=6 and wb_rd=30.
